// File: rtl/axi_bw_rr_allocator.sv
// B-channel allocator for one target port: arbitrates initiator-side B responses into a registered slice.
// Define AXI_BW_RR_EN for round-robin arbitration; otherwise the lowest asserted index wins.
module axi_bw_rr_allocator #(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_ID_W    = 5,
    parameter int AXI_USER_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    input  logic [N_INIT_PORT*AXI_ID_W-1:0]   bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    output logic [AXI_ID_W-1:0]               bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o
);

    localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    logic can_load;
    logic load;
    idx_t winner;

    assign can_load = !bvalid_o || bready_i;
    assign load     = !rst && can_load && (|bvalid_i);

`ifdef AXI_BW_RR_EN
    idx_t ptr;

    // Later assignments override earlier ones: the first pass picks the lowest
    // asserted index (wrap-around case), the second the lowest one at or above ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        winner = '0;
        for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
            if (bvalid_i[k]) winner = idx_t'(k);
        end
        for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
            if (bvalid_i[k] && (k >= int'(ptr))) winner = idx_t'(k);
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
            if (bvalid_i[k]) winner = idx_t'(k);
        end
    end
`endif

    always_comb begin
        bready_o = '0;
        if (load) bready_o[winner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: payload is reset too, so bid_o/bresp_o/buser_o read 0 out of reset.
            bvalid_o <= 1'b0;
            bid_o    <= '0;
            bresp_o  <= '0;
            buser_o  <= '0;
`ifdef AXI_BW_RR_EN
            ptr      <= '0;
`endif
        end else if (load) begin
            bvalid_o <= 1'b1;
            bid_o    <= bid_i[int'(winner)*AXI_ID_W +: AXI_ID_W];
            bresp_o  <= bresp_i[int'(winner)*2 +: 2];
            buser_o  <= buser_i[int'(winner)*AXI_USER_W +: AXI_USER_W];
`ifdef AXI_BW_RR_EN
            ptr      <= (int'(winner) == N_INIT_PORT - 1) ? '0 : winner + idx_t'(1);
`endif
        end else if (can_load) begin
            // Drained (or already empty) with nothing to load; payload holds.
            bvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_bw_rr_allocator.sv
// Randomized and directed bench for axi_bw_rr_allocator against a transaction-level model.
// Follows AXI_BW_RR_EN the same way the design does.
module tb_axi_bw_rr_allocator;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int UW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      bvalid_i;
    logic [N-1:0]      bready_o;
    logic [N*IW-1:0]   bid_i;
    logic [N*2-1:0]    bresp_i;
    logic [N*UW-1:0]   buser_i;
    logic              bvalid_o;
    logic              bready_i;
    logic [IW-1:0]     bid_o;
    logic [1:0]        bresp_o;
    logic [UW-1:0]     buser_o;

    axi_bw_rr_allocator #(.N_INIT_PORT(N), .AXI_ID_W(IW), .AXI_USER_W(UW)) dut (
        .clk(clk), .rst(rst),
        .bvalid_i(bvalid_i), .bready_o(bready_o),
        .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i),
        .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source payloads presented while a source is valid.
    logic [IW-1:0] src_id   [N];
    logic [1:0]    src_resp [N];
    logic [UW-1:0] src_user [N];

    // Model of the output slice and the arbitration pointer.
    logic          m_valid = 1'b0;
    logic [IW-1:0] m_id    = '0;
    logic [1:0]    m_resp  = '0;
    logic [UW-1:0] m_user  = '0;
    int            m_ptr   = 0;

    // Grant: in RR mode walk the sources in rotated order starting at m_ptr.
    function automatic int model_winner(input logic [N-1:0] v);
        int order[$];
`ifdef AXI_BW_RR_EN
        for (int k = m_ptr; k < N; k++) order.push_back(k);
        for (int k = 0; k < m_ptr; k++) order.push_back(k);
`else
        for (int k = 0; k < N; k++) order.push_back(k);
`endif
        foreach (order[i]) if (v[order[i]]) return order[i];
        return -1;
    endfunction

    // One clock: drive at negedge, check just before posedge, advance model at posedge.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic rdy, output int g);
        logic [N-1:0] exp_br;
        int w;
        @(negedge clk);
        rst      = r;
        bvalid_i = v;
        bready_i = rdy;
        for (int k = 0; k < N; k++) begin
            bid_i[k*IW +: IW]  = src_id[k];
            bresp_i[k*2 +: 2]  = src_resp[k];
            buser_i[k*UW +: UW] = src_user[k];
        end
        #1;
        w = model_winner(v);
        exp_br = '0;
        g = -1;
        if (!r && (!m_valid || rdy) && w >= 0) begin
            exp_br[w] = 1'b1;
            g = w;
        end
        check("bready_o", 32'(bready_o), 32'(exp_br));
        check("bvalid_o", 32'(bvalid_o), 32'(m_valid));
        check("bid_o",    32'(bid_o),    32'(m_id));
        check("bresp_o",  32'(bresp_o),  32'(m_resp));
        check("buser_o",  32'(buser_o),  32'(m_user));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0; m_id = '0; m_resp = '0; m_user = '0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_id    = src_id[g];
            m_resp  = src_resp[g];
            m_user  = src_user[g];
            m_ptr   = (g + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    int g;
    logic [N-1:0] pend;

    initial begin
        rst = 1'b1; bvalid_i = '0; bready_i = 1'b0;
        bid_i = '0; bresp_i = '0; buser_i = '0;
        for (int k = 0; k < N; k++) begin
            src_id[k]   = IW'(5'h04 + k);
            src_resp[k] = 2'(k);
            src_user[k] = UW'(6'h20 + k);
        end
        src_id[2] = 5'h11; src_resp[2] = 2'b00;

        // Reset state.
        cycle(1'b1, 4'b1111, 1'b1, g);
        cycle(1'b1, 4'b1111, 1'b1, g);
        check("reset_no_grant", 32'(g), 32'hFFFF_FFFF);

        // Single source 2 with bready_i high: grant now, visible next cycle, gone after.
        cycle(1'b0, 4'b0000, 1'b1, g);
        cycle(1'b0, 4'b0100, 1'b1, g);
        check("tp1_grant", 32'(g), 32'd2);
        #1;
        check("tp1_valid", 32'(bvalid_o), 32'd1);
        check("tp1_bid", 32'(bid_o), 32'h11);
        cycle(1'b0, 4'b0000, 1'b1, g);
        #1;
        check("tp1_drain", 32'(bvalid_o), 32'd0);

        // All sources valid continuously from ptr=0.
        cycle(1'b1, 4'b0000, 1'b0, g);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b1111, 1'b1, g);
`ifdef AXI_BW_RR_EN
            check("rr_order", 32'(g), 32'(i % N));
`else
            check("fixed_order", 32'(g), 32'd0);
`endif
        end

        // Stall with sources 1 and 3 waiting, then back-to-back release.
        cycle(1'b0, 4'b0001, 1'b1, g);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1010, 1'b0, g);
            check("stall_no_grant", 32'(g), 32'hFFFF_FFFF);
            check("stall_bid", 32'(bid_o), 32'(src_id[0]));
        end
        cycle(1'b0, 4'b1010, 1'b1, g);
        check("stall_release", 32'(g), 32'd1);
        #1;
        check("stall_next_bid", 32'(bid_o), 32'(src_id[1]));
        check("stall_next_valid", 32'(bvalid_o), 32'd1);

        // Wrap-around: grant 2 -> ptr 3, then only source 0.
        cycle(1'b0, 4'b0100, 1'b1, g);
        cycle(1'b0, 4'b0001, 1'b1, g);
        check("wrap_grant", 32'(g), 32'd0);
        cycle(1'b0, 4'b0011, 1'b1, g);
`ifdef AXI_BW_RR_EN
        check("wrap_ptr", 32'(g), 32'd1);
`else
        check("wrap_fixed", 32'(g), 32'd0);
`endif

        // Reset while a response is held and stalled.
        cycle(1'b0, 4'b0001, 1'b1, g);
        cycle(1'b0, 4'b0000, 1'b0, g);
        cycle(1'b1, 4'b1111, 1'b0, g);
        check("rst_mid_grant", 32'(g), 32'hFFFF_FFFF);
        #1;
        check("rst_mid_valid", 32'(bvalid_o), 32'd0);
        cycle(1'b1, 4'b1111, 1'b1, g);
        check("rst_mid_grant2", 32'(g), 32'hFFFF_FFFF);
        cycle(1'b0, 4'b1111, 1'b1, g);
        check("post_rst_grant", 32'(g), 32'd0);

        // Randomized traffic; a source holds valid and payload until handshaken.
        pend = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k]     = 1'b1;
                    src_id[k]   = IW'($urandom);
                    src_resp[k] = 2'($urandom);
                    src_user[k] = UW'($urandom);
                end
            end
            cycle(($urandom_range(99) == 0), pend, ($urandom_range(3) != 0), g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
